// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single-precision field types, constants and pack/unpack helpers
// shared by the adder sequencer and future multiplier front-ends.
package fp_pkg;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int WORD_W = 1 + EXP_W + FRAC_W;
   localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;
   typedef struct packed {
      logic              s;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W:0]   mant;
   } fp_fields_t;
   // Denormals and zero unpack with a clear hidden bit.
   function automatic fp_fields_t fp_unpack(input logic [WORD_W-1:0] w);
      fp_fields_t f;
      f.s    = w[WORD_W-1];
      f.exp  = w[WORD_W-2 -: EXP_W];
      f.mant = {|f.exp, w[FRAC_W-1:0]};
      return f;
   endfunction
   // Zero mantissa keeps the sign as signed zero; saturated exponent forces a clean infinity.
   function automatic logic [WORD_W-1:0] fp_pack(input fp_fields_t f);
      return (f.mant == '0) ? {f.s, {(WORD_W-1){1'b0}}} :
             (f.exp == EXP_MAX) ? {f.s, EXP_MAX, {FRAC_W{1'b0}}} :
             {f.s, f.exp, f.mant[FRAC_W-1:0]};
   endfunction
endpackage

// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: operand/result valid-ready streams plus the adder start/done bundle.
interface fp_add_sequencer_if;
   import fp_pkg::*;
   logic               in_valid, in_ready, in_op;
   logic [WORD_W-1:0]  in_a, in_b;
   logic               parin_s_A, parin_s_B;
   logic [EXP_W-1:0]   parin_exp_A, parin_exp_B;
   logic [FRAC_W:0]    parin_mant_A, parin_mant_B;
   logic               operator, start, done, s_outR;
   logic [EXP_W-1:0]   exp_outR;
   logic [FRAC_W:0]    mant_outR;
   logic               out_valid, out_ready, out_err;
   logic [WORD_W-1:0]  out_result;
   modport master (
      input  in_valid, in_a, in_b, in_op, done, s_outR, exp_outR, mant_outR, out_ready,
      output in_ready, parin_s_A, parin_s_B, parin_exp_A, parin_exp_B, parin_mant_A, parin_mant_B,
             operator, start, out_valid, out_result, out_err
   );
   modport slave (
      output in_valid, in_a, in_b, in_op, done, s_outR, exp_outR, mant_outR, out_ready,
      input  in_ready, parin_s_A, parin_s_B, parin_exp_A, parin_exp_B, parin_mant_A, parin_mant_B,
             operator, start, out_valid, out_result, out_err
   );
endinterface

// File: rtl/fp_pack_unpack.sv
// fp_pack_unpack: combinational converter between a packed IEEE word and its s/exp/mant fields.
module fp_pack_unpack
   import fp_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  fp_fields_t        i_fields,
   output fp_fields_t        o_fields,
   output logic [WORD_W-1:0] o_word
);
   assign o_fields = fp_unpack(i_word);
   assign o_word   = fp_pack(i_fields);
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: unpacks operand pairs for the fp adder, strobes start, waits for done
// (bounded by TIMEOUT) and returns the packed result on an output stream.
module fp_add_sequencer
   import fp_pkg::*;
#(
   parameter int TIMEOUT = 255
)(
   input  logic               clk,
   input  logic               rst,
   fp_add_sequencer_if.master bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   state_t            r_state, w_next;
   fp_fields_t        r_a, r_b, w_a, w_b, w_unused_r_fields;
   logic [WORD_W-1:0] r_result, w_r_word, w_unused_a_word, w_unused_b_word;
   logic [CNT_W-1:0]  r_cnt, w_cnt_inc;
   logic              r_op, r_err, w_timeout;

   fp_pack_unpack u_a (.i_word(bus.in_a), .i_fields('0), .o_fields(w_a), .o_word(w_unused_a_word));
   fp_pack_unpack u_b (.i_word(bus.in_b), .i_fields('0), .o_fields(w_b), .o_word(w_unused_b_word));
   fp_pack_unpack u_r (
      .i_word('0),
      .i_fields({bus.s_outR, bus.exp_outR, bus.mant_outR}),
      .o_fields(w_unused_r_fields),
      .o_word(w_r_word)
   );

   // Timeout fires on the WAIT cycle whose increment would bring the count to TIMEOUT.
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = w_cnt_inc == CNT_W'(TIMEOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.in_ready  = 1'b0;
      bus.start     = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            w_next       = bus.in_valid ? LOAD : IDLE;
         end
         LOAD:  w_next = START;
         START: begin
            bus.start = 1'b1;
            w_next    = WAIT;
         end
         WAIT:  w_next = (bus.done || w_timeout) ? OUT : WAIT;
         OUT: begin
            bus.out_valid = 1'b1;
            w_next        = bus.out_ready ? IDLE : OUT;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.in_valid) begin
            r_a  <= w_a;
            r_b  <= w_b;
            r_op <= bus.in_op;
         end
         if (r_state == START) r_cnt <= '0;
         if (r_state == WAIT) begin
            r_cnt    <= w_cnt_inc;
            r_result <= bus.done ? w_r_word : w_timeout ? QNAN : r_result;
            r_err    <= bus.done ? 1'b0 : w_timeout ? 1'b1 : r_err;
         end
      end
   end

   assign {bus.parin_s_A, bus.parin_exp_A, bus.parin_mant_A} = r_a;
   assign {bus.parin_s_B, bus.parin_exp_B, bus.parin_mant_B} = r_b;
   assign bus.operator   = r_op;
   assign bus.out_result = r_result;
   assign bus.out_err    = r_err;
endmodule
